// File: rtl/cve2_fetch_req_ctrl.sv
// Instruction-fetch bus request sequencer: issues word-aligned OBI requests, tracks outstanding
// transactions and squashes in-flight responses on branch. Optional counters: CVE2_FETCH_DISCARD_CNT_EN.
module cve2_fetch_req_ctrl #(
  parameter int NUM_REQS = 2,
  parameter bit ResetAll = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic                instr_err_i,
  output logic                busy_o
`ifdef CVE2_FETCH_DISCARD_CNT_EN
  ,
  output logic [15:0]         discard_cnt_o,
  output logic [15:0]         err_cnt_o
`endif
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] out_shift, disc_shift;
  logic                req_held_q, req_held_d;
  logic                held_branch_q, held_branch_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         stored_addr_q, stored_addr_d;
  logic [31:0]         branch_tgt;
  logic                fifo_ready, new_req, req_gnt, gnt_discard, slot_found;

  assign branch_tgt  = {branch_addr_i[31:2], 2'b00};
  assign fifo_ready  = ~&fifo_busy_i;
  assign new_req     = req_i & (fifo_ready | branch_i) & ~outstanding_q[NUM_REQS-1];
  assign instr_req_o = req_held_q | new_req;
  assign req_gnt     = instr_req_o & instr_gnt_i;
  // A held request that saw a branch (now or earlier) fetches a stale address.
  assign gnt_discard = req_held_q & (branch_i | held_branch_q);

  always_comb begin
    if (req_held_q) begin
      instr_addr_o = stored_addr_q;
    end else if (branch_i) begin
      instr_addr_o = branch_tgt;
    end else begin
      instr_addr_o = fetch_addr_q;
    end
  end

  always_comb begin
    req_held_d    = req_held_q;
    held_branch_d = held_branch_q;
    stored_addr_d = stored_addr_q;
    if (instr_req_o && !instr_gnt_i) begin
      req_held_d    = 1'b1;
      stored_addr_d = instr_addr_o;
      held_branch_d = held_branch_q | (req_held_q & branch_i);
    end else if (req_gnt) begin
      req_held_d    = 1'b0;
      held_branch_d = 1'b0;
    end
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      fetch_addr_d = (req_gnt && !req_held_q) ? branch_tgt + 32'd4 : branch_tgt;
    end else if (req_gnt && !gnt_discard) begin
      fetch_addr_d = instr_addr_o + 32'd4;
    end
  end

  // Response retires slot 0 first; a grant in the same cycle lands above the survivors.
  always_comb begin
    out_shift  = outstanding_q;
    disc_shift = discard_q | (branch_i ? outstanding_q : '0);
    if (instr_rvalid_i) begin
      out_shift  = out_shift >> 1;
      disc_shift = disc_shift >> 1;
    end
    outstanding_d = out_shift;
    discard_d     = disc_shift;
    slot_found    = 1'b0;
    if (req_gnt) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!slot_found && !out_shift[i]) begin
          outstanding_d[i] = 1'b1;
          discard_d[i]     = gnt_discard;
          slot_found       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      req_held_q    <= 1'b0;
      held_branch_q <= 1'b0;
      fetch_addr_q  <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      req_held_q    <= req_held_d;
      held_branch_q <= held_branch_d;
      fetch_addr_q  <= fetch_addr_d;
    end
  end

  if (ResetAll) begin : g_stored_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stored_addr_q <= '0;
      end else begin
        stored_addr_q <= stored_addr_d;
      end
    end
  end else begin : g_stored_nrst
    always_ff @(posedge clk_i) begin
      stored_addr_q <= stored_addr_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~discard_q[0];
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_addr_i;
  assign busy_o       = (|outstanding_q) | req_held_q;

`ifdef CVE2_FETCH_DISCARD_CNT_EN
  logic [15:0] discard_cnt_q, discard_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    err_cnt_d     = err_cnt_q;
    if (instr_rvalid_i && discard_q[0] && (discard_cnt_q != 16'hFFFF)) begin
      discard_cnt_d = discard_cnt_q + 16'd1;
    end
    if (instr_rvalid_i && !discard_q[0] && instr_err_i && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_cnt_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      discard_cnt_q <= discard_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign discard_cnt_o = discard_cnt_q;
  assign err_cnt_o     = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = instr_err_i;
`endif

`ifndef SYNTHESIS
  addr_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o && !instr_gnt_i) |=> (instr_addr_o == $past(instr_addr_o)));
  no_spurious_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (|outstanding_q));
`endif

endmodule

// File: tb/tb_cve2_fetch_req_ctrl.sv
// Directed bench for cve2_fetch_req_ctrl with hand-computed expected values (NUM_REQS=2).
module tb_cve2_fetch_req_ctrl;

  localparam int NR = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic          branch_i = 1'b0;
  logic [31:0]   branch_addr_i = '0;
  logic [NR-1:0] fifo_busy_i = '0;
  logic          fifo_clear_o, fifo_valid_o, instr_req_o, busy_o;
  logic [31:0]   fifo_addr_o, instr_addr_o;
  logic          instr_gnt_i = 1'b0;
  logic          instr_rvalid_i = 1'b0;
  logic          instr_err_i = 1'b0;
`ifdef CVE2_FETCH_DISCARD_CNT_EN
  logic [15:0]   discard_cnt_o, err_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  cve2_fetch_req_ctrl #(.NUM_REQS(NR), .ResetAll(1'b0)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .fifo_busy_i   (fifo_busy_i),
    .fifo_clear_o  (fifo_clear_o),
    .fifo_valid_o  (fifo_valid_o),
    .fifo_addr_o   (fifo_addr_o),
    .instr_req_o   (instr_req_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_addr_o  (instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_err_i   (instr_err_i),
    .busy_o        (busy_o)
`ifdef CVE2_FETCH_DISCARD_CNT_EN
    ,
    .discard_cnt_o (discard_cnt_o),
    .err_cnt_o     (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then settle at the falling edge.
  task automatic cyc(input logic r, input logic g, input logic v, input logic b,
                     input logic [31:0] ba, input logic [NR-1:0] fb);
    @(posedge clk_i);
    #1;
    req_i = r; instr_gnt_i = g; instr_rvalid_i = v; branch_i = b;
    branch_addr_i = ba; fifo_busy_i = fb;
    @(negedge clk_i);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_req", {31'd0, instr_req_o}, 32'd0);
    check("rst_fvalid", {31'd0, fifo_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;

    // Back-to-back sequential fetch, gnt always high, rvalid one cycle later
    cyc(1, 1, 0, 0, 0, 2'b00);
    check("seq_req0", {31'd0, instr_req_o}, 32'd1);
    check("seq_addr0", instr_addr_o, 32'h0);
    check("seq_fv0", {31'd0, fifo_valid_o}, 32'd0);
    cyc(1, 1, 1, 0, 0, 2'b00);
    check("seq_addr1", instr_addr_o, 32'h4);
    check("seq_fv1", {31'd0, fifo_valid_o}, 32'd1);
    check("gr_rv_busy", {31'd0, busy_o}, 32'd1);
    cyc(1, 1, 1, 0, 0, 2'b00);
    check("seq_addr2", instr_addr_o, 32'h8);
    check("seq_fv2", {31'd0, fifo_valid_o}, 32'd1);
    cyc(0, 0, 1, 0, 0, 2'b00);
    check("seq_req_off", {31'd0, instr_req_o}, 32'd0);
    check("seq_fv3", {31'd0, fifo_valid_o}, 32'd1);
    check("seq_busy_last", {31'd0, busy_o}, 32'd1);
    cyc(0, 0, 0, 0, 0, 2'b00);
    check("seq_idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_fv", {31'd0, fifo_valid_o}, 32'd0);

    // FIFO full gates requests; release issues at the next sequential address
    cyc(1, 1, 0, 0, 0, 2'b11);
    check("full_noreq", {31'd0, instr_req_o}, 32'd0);
    cyc(1, 1, 0, 0, 0, 2'b01);
    check("rel_req", {31'd0, instr_req_o}, 32'd1);
    check("rel_addr", instr_addr_o, 32'hC);
    cyc(0, 0, 1, 0, 0, 2'b00);
    check("rel_fv", {31'd0, fifo_valid_o}, 32'd1);

    // Two outstanding, branch to 0x40 with no free slot
    cyc(1, 1, 0, 0, 0, 2'b00);
    check("two_addr0", instr_addr_o, 32'h10);
    cyc(1, 1, 0, 0, 0, 2'b00);
    check("two_addr1", instr_addr_o, 32'h14);
    cyc(1, 1, 0, 1, 32'h40, 2'b00);
    check("two_br_noreq", {31'd0, instr_req_o}, 32'd0);
    check("two_br_clear", {31'd0, fifo_clear_o}, 32'd1);
    check("two_br_faddr", fifo_addr_o, 32'h40);
    cyc(1, 1, 1, 0, 0, 2'b00);
    check("two_full_noreq", {31'd0, instr_req_o}, 32'd0);
    check("two_drop0", {31'd0, fifo_valid_o}, 32'd0);
    check("two_clear_off", {31'd0, fifo_clear_o}, 32'd0);
    cyc(1, 1, 1, 0, 0, 2'b00);
    check("two_tgt_req", {31'd0, instr_req_o}, 32'd1);
    check("two_tgt_addr", instr_addr_o, 32'h40);
    check("two_drop1", {31'd0, fifo_valid_o}, 32'd0);
    cyc(0, 0, 1, 0, 0, 2'b00);
    check("two_tgt_push", {31'd0, fifo_valid_o}, 32'd1);

    // Held request at 0x100, branch while held, no retraction on req_i drop
    cyc(0, 0, 0, 1, 32'h100, 2'b00);
    check("hold_pre_noreq", {31'd0, instr_req_o}, 32'd0);
    cyc(1, 0, 0, 0, 0, 2'b00);
    check("hold_addr1", instr_addr_o, 32'h100);
    check("hold_req1", {31'd0, instr_req_o}, 32'd1);
    cyc(1, 0, 0, 1, 32'h206, 2'b00);
    check("hold_addr2", instr_addr_o, 32'h100);
    check("hold_clear2", {31'd0, fifo_clear_o}, 32'd1);
    check("hold_faddr2", fifo_addr_o, 32'h206);
    cyc(1, 0, 0, 0, 0, 2'b00);
    check("hold_addr3", instr_addr_o, 32'h100);
    check("hold_clear3", {31'd0, fifo_clear_o}, 32'd0);
    cyc(0, 1, 0, 0, 0, 2'b00);
    check("hold_noretract", {31'd0, instr_req_o}, 32'd1);
    check("hold_addr4", instr_addr_o, 32'h100);
    cyc(1, 1, 1, 0, 0, 2'b00);
    check("hold_drop", {31'd0, fifo_valid_o}, 32'd0);
    check("hold_tgt_addr", instr_addr_o, 32'h204);
    cyc(0, 0, 1, 0, 0, 2'b00);
    check("hold_tgt_push", {31'd0, fifo_valid_o}, 32'd1);

    // Async reset with one outstanding and one held request
    cyc(1, 1, 0, 0, 0, 2'b00);
    check("ar_addr0", instr_addr_o, 32'h208);
    cyc(1, 0, 0, 0, 0, 2'b00);
    check("ar_addr1", instr_addr_o, 32'h20C);
    check("ar_busy_pre", {31'd0, busy_o}, 32'd1);
    #2;
    req_i = 1'b0; instr_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("ar_req", {31'd0, instr_req_o}, 32'd0);
    check("ar_busy", {31'd0, busy_o}, 32'd0);
    check("ar_fv", {31'd0, fifo_valid_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1, 1, 0, 0, 0, 2'b00);
    check("post_rst_addr", instr_addr_o, 32'h0);
    cyc(0, 0, 1, 0, 0, 2'b00);
    check("post_rst_push", {31'd0, fifo_valid_o}, 32'd1);
    cyc(0, 0, 0, 0, 0, 2'b00);
    check("post_rst_idle", {31'd0, busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
